cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, clk_in cycles per CPU clock-enable pulse (legal range 1..256).
REQ-002 SHALL have parameter RST_CYCLES, default 8, clk_in cycles cpu_rst stays high after reset release (legal range 1..255).
REQ-003 SHALL have parameter AW, default 32, PC and breakpoint address width.
REQ-004 SHALL have parameter CNT_W, default 32, retired-cycle counter width.
REQ-005 SHALL have parameter START_HALTED, default 0; when 1, the block leaves reset hold into HALT instead of RUN.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port sw_rst, input, 1 bit: synchronous soft-reset request, single-cycle pulse.
REQ-009 SHALL have port run_req, input, 1 bit: pulse, resume execution.
REQ-010 SHALL have port halt_req, input, 1 bit: pulse, stop execution.
REQ-011 SHALL have port step_req, input, 1 bit: pulse, execute exactly one CPU cycle.
REQ-012 SHALL have port bp_en, input, 1 bit: breakpoint enable.
REQ-013 SHALL have port bp_addr, input, AW bits: breakpoint address.
REQ-014 SHALL have port pc, input, AW bits: current CPU program counter.
REQ-015 SHALL have port cpu_ce, output, 1 bit: one-clk_in-cycle CPU clock enable.
REQ-016 SHALL have port cpu_rst, output, 1 bit: active-high CPU reset.
REQ-017 SHALL have port state, output, 2 bits: current state encoding.
REQ-018 SHALL have port bp_hit, output, 1 bit: sticky breakpoint-hit flag.
REQ-019 SHALL have port cycle_cnt, output, CNT_W bits: number of cpu_ce pulses issued.

Function
REQ-020 SHALL implement states RHOLD=0, HALT=1, RUN=2, STEP=3.
REQ-021 SHALL keep a prescaler counting 0..DIV-1 in RUN and STEP only, hold it at 0 elsewhere, and raise tick when it equals DIV-1 (DIV=1: tick every cycle).
REQ-022 In RHOLD, SHALL assert cpu_rst, count RST_CYCLES cycles, then enter HALT if START_HALTED=1, else RUN.
REQ-023 In RUN, SHALL assert cpu_ce on each tick unless a breakpoint fires.
REQ-024 A breakpoint SHALL fire on a RUN tick when bp_en=1, pc==bp_addr and skip=0: no cpu_ce is issued, bp_hit is set, and the next state is HALT.
REQ-025 SHALL set an internal skip flag on every HALT->RUN transition and clear it at the first RUN tick, so a resume from a breakpoint executes that instruction.
REQ-026 In HALT, step_req SHALL go to STEP; otherwise run_req SHALL go to RUN; otherwise the block stays in HALT.
REQ-027 In STEP, SHALL issue exactly one cpu_ce on the first tick, ignore the breakpoint, and then return to HALT.
REQ-028 halt_req in RUN or STEP SHALL go to HALT next cycle; no cpu_ce is issued in that cycle, even if tick coincides.
REQ-029 Priority SHALL be sw_rst > halt_req > breakpoint > step_req > run_req.
REQ-030 sw_rst in any state SHALL enter RHOLD, reload the hold counter, and clear bp_hit and cycle_cnt.
REQ-031 run_req and step_req SHALL be ignored in RHOLD, RUN and STEP.
REQ-032 cycle_cnt SHALL increment on each cpu_ce and wrap modulo 2^CNT_W.
REQ-033 bp_hit SHALL clear on run_req or step_req accepted from HALT.
REQ-034 cpu_ce, cpu_rst, state and bp_hit SHALL be registered outputs.

Reset
REQ-035 On reset low, SHALL asynchronously force state=RHOLD, cpu_rst=1, cpu_ce=0, bp_hit=0, cycle_cnt=0, prescaler=0, skip=0, and hold counter=RST_CYCLES.
REQ-036 The RHOLD count SHALL begin on the first clk_in edge after reset deasserts.

Structure
REQ-037 Package cpu_run_ctrl_pkg SHALL hold the state encodings and the 2-bit state type.
REQ-038 The prescaler SHALL be sub-module ce_prescaler, with inputs enable and clear, output tick, and parameter DIV.

Verification
REQ-039 DIV=4, RST_CYCLES=3, START_HALTED=0, release reset -> cpu_rst high 3 cycles, then cpu_ce every 4th cycle; cycle_cnt=5 after 20 RUN cycles.
REQ-040 START_HALTED=1, pulse step_req twice (10 cycles apart) -> exactly 2 cpu_ce pulses, state returns to 1, cycle_cnt=2.
REQ-041 bp_en=1, bp_addr=0x0000_0010, pc reaches 0x10 -> no cpu_ce at that tick, bp_hit=1, state=1; run_req -> next tick issues cpu_ce, bp_hit=0.
REQ-042 halt_req in the same cycle as tick -> no cpu_ce, state=1 next cycle; run_req and step_req in the same cycle -> state=3.
REQ-043 CNT_W=4, 17 cpu_ce pulses -> cycle_cnt=1; sw_rst mid-RUN -> cycle_cnt=0, cpu_rst=1 for RST_CYCLES cycles.
REQ-044 reset low mid-RUN, asynchronously between clk_in edges -> all outputs take reset values immediately; DIV=1 -> cpu_ce high every RUN cycle.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encoding for the CPU run controller and anything that decodes its state port.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RHOLD = 2'd0,
        ST_HALT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

endpackage

// File: rtl/ce_prescaler.sv
// Divides clk_in down to a one-cycle tick every DIV cycles while enabled; clear parks the count at 0.
module ce_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With DIV=1 the count never leaves 0, so the enable gate keeps tick quiet while halted.
    assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller for a CPU core: reset hold, clock-enable generation, breakpoint and cycle count.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DIV          = 4,
    parameter int RST_CYCLES   = 8,
    parameter int AW           = 32,
    parameter int CNT_W        = 32,
    parameter int START_HALTED = 0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sw_rst,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    input  logic [AW-1:0]    pc,
    output logic             cpu_ce,
    output logic             cpu_rst,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [7:0] HOLD_INIT = 8'(RST_CYCLES);

    state_t             state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               cpu_ce_q, cpu_ce_d;
    logic               bp_hit_q, bp_hit_d;
    logic               skip_q, skip_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_like;
    logic               tick;
    logic               bp_fire;

    assign run_like = (state_q == ST_RUN) || (state_q == ST_STEP);

    ce_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk_in (clk_in),
        .reset  (reset),
        .enable (run_like),
        .clear  (!run_like),
        .tick   (tick)
    );

    // skip lets a resume execute the instruction that the breakpoint stopped on.
    assign bp_fire = bp_en && (pc == bp_addr) && !skip_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cpu_rst_d = 1'b0;
        cpu_ce_d  = 1'b0;
        bp_hit_d  = bp_hit_q;
        skip_d    = skip_q;
        cnt_d     = cnt_q;
        if (sw_rst) begin
            state_d   = ST_RHOLD;
            hold_d    = HOLD_INIT;
            cpu_rst_d = 1'b1;
            bp_hit_d  = 1'b0;
            skip_d    = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_RHOLD: begin
                    if (hold_q <= 8'd1) begin
                        state_d = (START_HALTED != 0) ? ST_HALT : ST_RUN;
                    end else begin
                        hold_d    = hold_q - 8'd1;
                        cpu_rst_d = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (step_req) begin
                        state_d  = ST_STEP;
                        bp_hit_d = 1'b0;
                    end else if (run_req) begin
                        state_d  = ST_RUN;
                        skip_d   = 1'b1;
                        bp_hit_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (tick) begin
                        skip_d = 1'b0;
                        if (bp_fire) begin
                            state_d  = ST_HALT;
                            bp_hit_d = 1'b1;
                        end else begin
                            cpu_ce_d = 1'b1;
                            cnt_d    = cnt_q + 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (tick) begin
                        state_d  = ST_HALT;
                        cpu_ce_d = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_RHOLD;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RHOLD;
            hold_q    <= HOLD_INIT;
            cpu_rst_q <= 1'b1;
            cpu_ce_q  <= 1'b0;
            bp_hit_q  <= 1'b0;
            skip_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_ce_q  <= cpu_ce_d;
            bp_hit_q  <= bp_hit_d;
            skip_q    <= skip_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign cpu_rst   = cpu_rst_q;
    assign state     = state_q;
    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three instances cover run/bp/wrap (A), start-halted stepping (B) and DIV=1 (C).
module tb_cpu_run_ctrl;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic idle   = 1'b0;
    logic [31:0] zero_aw = '0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic        a_sw_rst = 0, a_run = 0, a_halt = 0, a_step = 0, a_bp_en = 0;
    logic [31:0] a_bp_addr = '0, a_pc = '0;
    logic        a_ce, a_rst, a_bp_hit;
    logic [1:0]  a_state;
    logic [3:0]  a_cnt;

    logic        b_step = 0;
    logic        b_ce, b_rst, b_bp_hit;
    logic [1:0]  b_state;
    logic [31:0] b_cnt;

    logic        c_ce, c_rst, c_bp_hit;
    logic [1:0]  c_state;
    logic [31:0] c_cnt;

    always #5 clk_in = ~clk_in;

    cpu_run_ctrl #(.DIV(4), .RST_CYCLES(3), .AW(32), .CNT_W(4), .START_HALTED(0)) u_a (
        .clk_in(clk_in), .reset(reset), .sw_rst(a_sw_rst), .run_req(a_run), .halt_req(a_halt),
        .step_req(a_step), .bp_en(a_bp_en), .bp_addr(a_bp_addr), .pc(a_pc),
        .cpu_ce(a_ce), .cpu_rst(a_rst), .state(a_state), .bp_hit(a_bp_hit), .cycle_cnt(a_cnt)
    );

    cpu_run_ctrl #(.DIV(4), .RST_CYCLES(3), .AW(32), .CNT_W(32), .START_HALTED(1)) u_b (
        .clk_in(clk_in), .reset(reset), .sw_rst(idle), .run_req(idle), .halt_req(idle),
        .step_req(b_step), .bp_en(idle), .bp_addr(zero_aw), .pc(zero_aw),
        .cpu_ce(b_ce), .cpu_rst(b_rst), .state(b_state), .bp_hit(b_bp_hit), .cycle_cnt(b_cnt)
    );

    cpu_run_ctrl #(.DIV(1), .RST_CYCLES(2), .AW(32), .CNT_W(32), .START_HALTED(0)) u_c (
        .clk_in(clk_in), .reset(reset), .sw_rst(idle), .run_req(idle), .halt_req(idle),
        .step_req(idle), .bp_en(idle), .bp_addr(zero_aw), .pc(zero_aw),
        .cpu_ce(c_ce), .cpu_rst(c_rst), .state(c_state), .bp_hit(c_bp_hit), .cycle_cnt(c_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        // power-on reset
        #1 reset = 1'b0;
        #2;
        chk("por_state", a_state, 2'd0);
        chk("por_cpu_rst", a_rst, 1'b1);
        chk("por_cpu_ce", a_ce, 1'b0);
        chk("por_bp_hit", a_bp_hit, 1'b0);
        chk("por_cnt", a_cnt, 4'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1 reset = 1'b1;
        chk("hold_pre_e1", a_rst, 1'b1);

        // reset hold length and entry state
        cyc(1);
        chk("hold_e1_a", a_rst, 1'b1);
        chk("hold_e1_c", c_rst, 1'b1);
        cyc(1);
        chk("hold_e2_a", a_rst, 1'b1);
        chk("hold_e2_a_state", a_state, 2'd0);
        chk("c_run_e2", c_state, 2'd2);
        chk("c_rst_e2", c_rst, 1'b0);
        cyc(1);
        chk("a_rst_released", a_rst, 1'b0);
        chk("a_state_run", a_state, 2'd2);
        chk("b_start_halted", b_state, 2'd1);
        chk("b_rst_released", b_rst, 1'b0);

        // 20 RUN cycles: A every 4th, C every cycle
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk("a_ce_cadence", a_ce, ((k % 4) == 0));
            chk("c_ce_div1", c_ce, 1'b1);
        end
        chk("a_cnt_20", a_cnt, 4'd5);
        chk("c_cnt_20", c_cnt, 32'd21);

        // halt_req on the tick cycle suppresses cpu_ce
        cyc(3);
        a_halt = 1'b1;
        cyc(1);
        a_halt = 1'b0;
        chk("halt_tick_ce", a_ce, 1'b0);
        chk("halt_tick_state", a_state, 2'd1);
        chk("halt_tick_cnt", a_cnt, 4'd5);

        // run_req and step_req together: step wins
        a_run = 1'b1;
        a_step = 1'b1;
        cyc(1);
        a_run = 1'b0;
        a_step = 1'b0;
        chk("step_prio", a_state, 2'd3);
        cyc(3);
        chk("step_wait_ce", a_ce, 1'b0);
        cyc(1);
        chk("step_ce", a_ce, 1'b1);
        chk("step_back_halt", a_state, 2'd1);
        chk("step_cnt", a_cnt, 4'd6);
        cyc(1);
        chk("step_single", a_ce, 1'b0);

        // breakpoint at 0x10
        a_pc = 32'h0000_000C;
        a_bp_addr = 32'h0000_0010;
        a_bp_en = 1'b1;
        a_run = 1'b1;
        cyc(1);
        a_run = 1'b0;
        chk("resume_run", a_state, 2'd2);
        cyc(4);
        chk("pre_bp_ce", a_ce, 1'b1);
        chk("pre_bp_cnt", a_cnt, 4'd7);
        a_pc = 32'h0000_0010;
        cyc(4);
        chk("bp_no_ce", a_ce, 1'b0);
        chk("bp_hit_set", a_bp_hit, 1'b1);
        chk("bp_state", a_state, 2'd1);
        chk("bp_cnt", a_cnt, 4'd7);
        a_run = 1'b1;
        cyc(1);
        a_run = 1'b0;
        chk("bp_resume_state", a_state, 2'd2);
        chk("bp_hit_clear", a_bp_hit, 1'b0);
        cyc(4);
        chk("bp_skip_ce", a_ce, 1'b1);
        chk("bp_skip_cnt", a_cnt, 4'd8);

        // soft reset mid-RUN
        a_bp_en = 1'b0;
        a_sw_rst = 1'b1;
        cyc(1);
        a_sw_rst = 1'b0;
        chk("sw_state", a_state, 2'd0);
        chk("sw_rst_1", a_rst, 1'b1);
        chk("sw_cnt", a_cnt, 4'd0);
        chk("sw_ce", a_ce, 1'b0);
        cyc(1);
        chk("sw_rst_2", a_rst, 1'b1);
        cyc(1);
        chk("sw_rst_3", a_rst, 1'b1);
        cyc(1);
        chk("sw_rst_done", a_rst, 1'b0);
        chk("sw_run", a_state, 2'd2);

        // 4-bit counter wrap: pulse 16 -> 0, pulse 17 -> 1
        cyc(4);
        chk("wrap_first", a_cnt, 4'd1);
        cyc(63);
        chk("wrap_16", a_cnt, 4'd0);
        cyc(1);
        chk("wrap_17_ce", a_ce, 1'b1);
        chk("wrap_17", a_cnt, 4'd1);

        // B: two single steps ten cycles apart
        b_step = 1'b1;
        cyc(1);
        b_step = 1'b0;
        chk("b_step_state", b_state, 2'd3);
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            pulses += int'(b_ce);
        end
        b_step = 1'b1;
        cyc(1);
        pulses += int'(b_ce);
        b_step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            pulses += int'(b_ce);
        end
        chk("b_pulses", pulses, 2);
        chk("b_state_end", b_state, 2'd1);
        chk("b_cnt", b_cnt, 32'd2);

        // asynchronous reset between edges
        chk("c_ce_pre_reset", c_ce, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_c_state", c_state, 2'd0);
        chk("async_c_rst", c_rst, 1'b1);
        chk("async_c_ce", c_ce, 1'b0);
        chk("async_c_cnt", c_cnt, 32'd0);
        chk("async_c_bp", c_bp_hit, 1'b0);
        chk("async_a_state", a_state, 2'd0);
        chk("async_a_cnt", a_cnt, 4'd0);
        chk("async_b_cnt", b_cnt, 32'd0);
        chk("async_b_bp", b_bp_hit, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
